// File: rtl/wired_lsu_sb_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// wired_lsu_sb_ctrl_pkg
//   Shared types and constants for the LSU store-buffer controller.
//   - sb_meta_t         : per-entry metadata exported by each sb entry
//                         (physical address plus snoop-updated writable hit ways)
//   - dsram_snoop_t     : dcache SRAM snoop event seen by the sb entries
//   - sb_drain_state_e  : drain FSM encoding (INIT / IDLE / WRITE / MISS)
//   - SB_DEPTH_DEF / SB_PTR_W : default depth and the derived pointer width
// ----------------------------------------------------------------------------
package wired_lsu_sb_ctrl_pkg;

    localparam int SB_DEPTH_DEF = 4;
    localparam int SB_PTR_W     = $clog2(SB_DEPTH_DEF);
    localparam int SB_WAYS      = 4;

    // Entry metadata; hit holds the ways that are present and writable.
    typedef struct packed {
        logic [31:0]        paddr;
        logic [SB_WAYS-1:0] hit;
    } sb_meta_t;

    // Snoop event from the dcache SRAM side; entries use it to update hit.
    typedef struct packed {
        logic               valid;
        logic [31:0]        paddr;
        logic [SB_WAYS-1:0] way;
        logic               evict;
        logic               wr_revoke;
    } dsram_snoop_t;

    typedef enum logic [1:0] {
        SB_ST_INIT  = 2'd0,
        SB_ST_IDLE  = 2'd1,
        SB_ST_WRITE = 2'd2,
        SB_ST_MISS  = 2'd3
    } sb_drain_state_e;

endpackage

// File: rtl/wired_lsu_sb_ptr.sv
// ----------------------------------------------------------------------------
// wired_lsu_sb_ptr
//   Wrapping pointer over a power-of-two ring. Load has priority over
//   increment; the increment wraps naturally through the PTR_W-bit width.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//     inc        : advance pointer by one
//     load       : replace pointer with load_val
//     load_val   : value loaded when load is high
//     ptr        : current pointer value
// ----------------------------------------------------------------------------
module wired_lsu_sb_ptr #(
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             load,
    input  logic [PTR_W-1:0] load_val,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] ptr_nxt_s;

    // Next pointer: load wins over increment.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (load) begin
            ptr_nxt_s = load_val;
        end else if (inc) begin
            ptr_nxt_s = ptr_r + PTR_W'(1'b1);
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {PTR_W{1'b0}};
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/wired_lsu_sb_ctrl.sv
// ----------------------------------------------------------------------------
// wired_lsu_sb_ctrl
//   Store-buffer controller: keeps head (drain), commit and tail (alloc)
//   pointers over SB_DEPTH entries, produces per-entry set/clear strobes,
//   drains committed entries in order to the dcache data SRAM writer and
//   raises a miss request when the head entry has no writable way.
//   Ports:
//     push_valid_i/push_ready_o/push_idx_o : entry allocation from store pipe
//     commit_i                             : commit oldest uncommitted entry
//     flush_i                              : drop all uncommitted entries
//     ent_set_o / ent_clr_o                : per-entry valid / invalidate strobes
//     ent_meta_i                           : per-entry paddr + snooped hit ways
//     wr_valid_o/wr_ready_i/wr_idx_o/
//     wr_way_o/wr_paddr_o                  : head-entry SRAM write request
//     miss_req_o/miss_paddr_o/miss_ack_i   : refill / upgrade request for head
//     full_o/empty_o/count_o               : occupancy
// ----------------------------------------------------------------------------
module wired_lsu_sb_ctrl
    import wired_lsu_sb_ctrl_pkg::*;
#(
    parameter int SB_DEPTH = SB_DEPTH_DEF,
    parameter int PTR_W    = $clog2(SB_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_valid_i,
    output logic                          push_ready_o,
    output logic [PTR_W-1:0]              push_idx_o,
    input  logic                          commit_i,
    input  logic                          flush_i,
    output logic [SB_DEPTH-1:0]           ent_set_o,
    output logic [SB_DEPTH-1:0]           ent_clr_o,
    input  sb_meta_t [SB_DEPTH-1:0]       ent_meta_i,
    output logic                          wr_valid_o,
    input  logic                          wr_ready_i,
    output logic [PTR_W-1:0]              wr_idx_o,
    output logic [3:0]                    wr_way_o,
    output logic [31:0]                   wr_paddr_o,
    output logic                          miss_req_o,
    output logic [31:0]                   miss_paddr_o,
    input  logic                          miss_ack_i,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [PTR_W:0]                count_o
);

    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_INIT  = SB_ST_INIT;
    localparam logic [1:0] ST_IDLE  = SB_ST_IDLE;
    localparam logic [1:0] ST_WRITE = SB_ST_WRITE;
    localparam logic [1:0] ST_MISS  = SB_ST_MISS;

    logic [1:0]          state_r;
    logic [1:0]          state_nxt_s;
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    cmt_cnt_r;
    logic [CNT_W-1:0]    count_nxt_s;
    logic [CNT_W-1:0]    cmt_cnt_nxt_s;
    logic [CNT_W-1:0]    uncmt_s;
    logic [CNT_W-1:0]    uncmt_left_s;
    logic                full_r;
    logic                empty_r;
    logic [31:0]         miss_paddr_r;
    logic                miss_cap_s;

    logic [PTR_W-1:0]    head_s;
    logic [PTR_W-1:0]    cmt_ptr_s;
    logic [PTR_W-1:0]    tail_s;
    logic [PTR_W-1:0]    cmt_ptr_nxt_s;

    logic                push_ready_s;
    logic                push_fire_s;
    logic                commit_fire_s;
    logic                in_write_s;
    logic                wr_valid_s;
    logic                drain_fire_s;
    logic                init_clr_s;

    sb_meta_t            head_meta_s;
    logic [3:0]          head_hit_s;
    logic [3:0]          head_way_s;

    logic [SB_DEPTH-1:0] set_s;
    logic [SB_DEPTH-1:0] drain_clr_s;
    logic [SB_DEPTH-1:0] flush_clr_s;

    // ------------------------------------------------------------------
    // Handshakes and derived counts
    // ------------------------------------------------------------------
    assign head_meta_s  = ent_meta_i[head_s];
    assign head_hit_s   = head_meta_s.hit;
    // Isolate the lowest set hit bit: x & (-x).
    assign head_way_s   = head_hit_s & (~head_hit_s + 4'b0001);

    // Push is judged on the registered count; a same-cycle drain does not free a slot.
    assign push_ready_s  = !full_r && !flush_i && (state_r != ST_INIT);
    assign push_fire_s   = push_valid_i && push_ready_s;
    assign uncmt_s       = count_r - cmt_cnt_r;
    assign commit_fire_s = commit_i && (uncmt_s != {CNT_W{1'b0}});
    assign in_write_s    = (state_r == ST_WRITE);
    // Valid follows the live hit bits, so a snoop can withdraw it.
    assign wr_valid_s    = in_write_s && (head_hit_s != 4'b0000);
    assign drain_fire_s  = wr_valid_s && wr_ready_i;
    // Entries carry no reset, so the whole array is invalidated once on reset release.
    assign init_clr_s    = (state_r == ST_INIT) && rst_n;

    // A same-cycle commit is applied before the flush, so the flush starts after it.
    assign cmt_ptr_nxt_s = commit_fire_s ? (cmt_ptr_s + PTR_W'(1'b1)) : cmt_ptr_s;
    assign uncmt_left_s  = uncmt_s - {{PTR_W{1'b0}}, commit_fire_s};

    // Committed and total occupancy for next cycle.
    always_comb begin
        cmt_cnt_nxt_s = cmt_cnt_r + {{PTR_W{1'b0}}, commit_fire_s}
                                  - {{PTR_W{1'b0}}, drain_fire_s};
        if (flush_i) begin
            count_nxt_s = cmt_cnt_nxt_s;
        end else begin
            count_nxt_s = count_r + {{PTR_W{1'b0}}, push_fire_s}
                                  - {{PTR_W{1'b0}}, drain_fire_s};
        end
    end

    // ------------------------------------------------------------------
    // Pointers
    // ------------------------------------------------------------------
    wired_lsu_sb_ptr #(.PTR_W(PTR_W)) u_head_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (drain_fire_s),
        .load     (1'b0),
        .load_val ({PTR_W{1'b0}}),
        .ptr      (head_s)
    );

    wired_lsu_sb_ptr #(.PTR_W(PTR_W)) u_cmt_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (commit_fire_s),
        .load     (1'b0),
        .load_val ({PTR_W{1'b0}}),
        .ptr      (cmt_ptr_s)
    );

    // Flush rewinds tail to the first uncommitted slot; push is blocked during flush.
    wired_lsu_sb_ptr #(.PTR_W(PTR_W)) u_tail_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (push_fire_s),
        .load     (flush_i),
        .load_val (cmt_ptr_nxt_s),
        .ptr      (tail_s)
    );

    // ------------------------------------------------------------------
    // Per-entry strobes
    // ------------------------------------------------------------------
    // Set at tail on push, clear at head on drain, clear the flushed span.
    always_comb begin
        set_s       = {SB_DEPTH{1'b0}};
        drain_clr_s = {SB_DEPTH{1'b0}};
        flush_clr_s = {SB_DEPTH{1'b0}};
        for (int i = 0; i < SB_DEPTH; i++) begin
            set_s[i]       = push_fire_s  && (tail_s == PTR_W'(i));
            drain_clr_s[i] = drain_fire_s && (head_s == PTR_W'(i));
            // Distance from the flush start, modulo depth, against the span length.
            if (flush_i && ({1'b0, PTR_W'(PTR_W'(i) - cmt_ptr_nxt_s)} < uncmt_left_s)) begin
                flush_clr_s[i] = 1'b1;
            end else begin
                flush_clr_s[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    // Next-state logic; miss_cap_s marks every entry into MISS.
    always_comb begin
        state_nxt_s = state_r;
        miss_cap_s  = 1'b0;
        case (state_r)
            ST_INIT: begin
                state_nxt_s = ST_IDLE;
            end
            ST_IDLE: begin
                if (cmt_cnt_r != {CNT_W{1'b0}}) begin
                    if (head_hit_s != 4'b0000) begin
                        state_nxt_s = ST_WRITE;
                    end else begin
                        state_nxt_s = ST_MISS;
                        miss_cap_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (drain_fire_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (head_hit_s == 4'b0000) begin
                    state_nxt_s = ST_MISS;
                    miss_cap_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_MISS: begin
                if (miss_ack_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_MISS;
                end
            end
            default: begin
                state_nxt_s = ST_INIT;
            end
        endcase
    end

    // State, occupancy and miss address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_INIT;
            count_r      <= {CNT_W{1'b0}};
            cmt_cnt_r    <= {CNT_W{1'b0}};
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            miss_paddr_r <= 32'h0000_0000;
        end else begin
            state_r   <= state_nxt_s;
            count_r   <= count_nxt_s;
            cmt_cnt_r <= cmt_cnt_nxt_s;
            full_r    <= (count_nxt_s == CNT_W'(SB_DEPTH));
            empty_r   <= (count_nxt_s == {CNT_W{1'b0}});
            if (miss_cap_s) begin
                miss_paddr_r <= head_meta_s.paddr;
            end else begin
                miss_paddr_r <= miss_paddr_r;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign push_ready_o = push_ready_s;
    assign push_idx_o   = tail_s;
    assign ent_set_o    = set_s;
    assign ent_clr_o    = init_clr_s ? {SB_DEPTH{1'b1}} : (flush_clr_s | drain_clr_s);
    assign wr_valid_o   = wr_valid_s;
    assign wr_idx_o     = head_s;
    assign wr_way_o     = in_write_s ? head_way_s : 4'b0000;
    assign wr_paddr_o   = in_write_s ? head_meta_s.paddr : 32'h0000_0000;
    assign miss_req_o   = (state_r == ST_MISS);
    assign miss_paddr_o = (state_r == ST_MISS) ? miss_paddr_r : 32'h0000_0000;
    assign full_o       = full_r;
    assign empty_o      = empty_r;
    assign count_o      = count_r;

endmodule

// File: tb/tb_wired_lsu_sb_ctrl.sv
// ----------------------------------------------------------------------------
// tb_wired_lsu_sb_ctrl
//   Directed, table-driven bench for wired_lsu_sb_ctrl (SB_DEPTH = 4).
//   Each table row is one clock cycle: inputs driven after the falling edge,
//   outputs compared 1 time unit later, state advances on the next rising edge.
//   Entry e has paddr 0x8000_0000 + e*0x100; row field hit packs the hit ways
//   of entries 3..0 as four nibbles.
// ----------------------------------------------------------------------------
module tb_wired_lsu_sb_ctrl;
    import wired_lsu_sb_ctrl_pkg::*;

    localparam logic [31:0] PA0 = 32'h8000_0000;
    localparam logic [31:0] PA1 = 32'h8000_0100;
    localparam logic [31:0] PA2 = 32'h8000_0200;
    localparam logic [31:0] PA3 = 32'h8000_0300;

    logic           clk;
    logic           rst_n;
    logic           push_valid;
    logic           push_ready;
    logic [1:0]     push_idx;
    logic           commit;
    logic           flush;
    logic [3:0]     ent_set;
    logic [3:0]     ent_clr;
    sb_meta_t [3:0] meta;
    logic           wr_valid;
    logic           wr_ready;
    logic [1:0]     wr_idx;
    logic [3:0]     wr_way;
    logic [31:0]    wr_paddr;
    logic           miss_req;
    logic [31:0]    miss_paddr;
    logic           miss_ack;
    logic           full;
    logic           empty;
    logic [2:0]     count;

    int checks = 0;
    int errors = 0;

    wired_lsu_sb_ctrl #(.SB_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (push_valid),
        .push_ready_o (push_ready),
        .push_idx_o   (push_idx),
        .commit_i     (commit),
        .flush_i      (flush),
        .ent_set_o    (ent_set),
        .ent_clr_o    (ent_clr),
        .ent_meta_i   (meta),
        .wr_valid_o   (wr_valid),
        .wr_ready_i   (wr_ready),
        .wr_idx_o     (wr_idx),
        .wr_way_o     (wr_way),
        .wr_paddr_o   (wr_paddr),
        .miss_req_o   (miss_req),
        .miss_paddr_o (miss_paddr),
        .miss_ack_i   (miss_ack),
        .full_o       (full),
        .empty_o      (empty),
        .count_o      (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        pv;
        logic        cm;
        logic        fl;
        logic        wrr;
        logic        ack;
        logic [15:0] hit;
        logic        prdy;
        logic [1:0]  pidx;
        logic [3:0]  set;
        logic [3:0]  clr;
        logic        wv;
        logic [1:0]  widx;
        logic [3:0]  wway;
        logic [31:0] wpa;
        logic        mreq;
        logic [31:0] mpa;
        logic [2:0]  cnt;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic pv, input logic cm, input logic fl, input logic wrr, input logic ack,
        input logic [15:0] hit, input logic prdy, input logic [1:0] pidx,
        input logic [3:0] set, input logic [3:0] clr, input logic wv, input logic [1:0] widx,
        input logic [3:0] wway, input logic [31:0] wpa, input logic mreq,
        input logic [31:0] mpa, input logic [2:0] cnt);
        vec_t v;
        v.pv = pv; v.cm = cm; v.fl = fl; v.wrr = wrr; v.ack = ack; v.hit = hit;
        v.prdy = prdy; v.pidx = pidx; v.set = set; v.clr = clr; v.wv = wv;
        v.widx = widx; v.wway = wway; v.wpa = wpa; v.mreq = mreq; v.mpa = mpa;
        v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %h, want %h", nm, idx, act, exp);
        end
    endtask

    task automatic set_hits(input logic [15:0] hit);
        for (int e = 0; e < 4; e++) begin
            meta[e].hit   = hit[4*e +: 4];
            meta[e].paddr = PA0 + 32'(e) * 32'h0000_0100;
        end
    endtask

    task automatic drive_idle();
        push_valid = 1'b0;
        commit     = 1'b0;
        flush      = 1'b0;
        wr_ready   = 1'b0;
        miss_ack   = 1'b0;
    endtask

    // Every output at its reset value: all zero except empty.
    task automatic chk_reset_outs(input int tag);
        chk("rst push_ready", tag, 32'(push_ready), 32'd0);
        chk("rst push_idx",   tag, 32'(push_idx),   32'd0);
        chk("rst ent_set",    tag, 32'(ent_set),    32'd0);
        chk("rst ent_clr",    tag, 32'(ent_clr),    32'd0);
        chk("rst wr_valid",   tag, 32'(wr_valid),   32'd0);
        chk("rst wr_idx",     tag, 32'(wr_idx),     32'd0);
        chk("rst wr_way",     tag, 32'(wr_way),     32'd0);
        chk("rst wr_paddr",   tag, wr_paddr,        32'd0);
        chk("rst miss_req",   tag, 32'(miss_req),   32'd0);
        chk("rst miss_paddr", tag, miss_paddr,      32'd0);
        chk("rst count",      tag, 32'(count),      32'd0);
        chk("rst full",       tag, 32'(full),       32'd0);
        chk("rst empty",      tag, 32'(empty),      32'd1);
    endtask

    initial begin
        //              pv cm fl wr ak  hit       prdy pidx  set      clr      wv widx  way      wpa  mq mpa  cnt
        // reset release: INIT then IDLE
        vecs[0]  = mk(0,0,0,0,0,16'h4444, 0,2'd0,4'b0000,4'b1111,0,2'd0,4'b0000,32'd0,0,32'd0,3'd0);
        vecs[1]  = mk(0,0,0,0,0,16'h4444, 1,2'd0,4'b0000,4'b0000,0,2'd0,4'b0000,32'd0,0,32'd0,3'd0);
        // fill 0..3, fifth push refused
        vecs[2]  = mk(1,0,0,0,0,16'h4444, 1,2'd0,4'b0001,4'b0000,0,2'd0,4'b0000,32'd0,0,32'd0,3'd0);
        vecs[3]  = mk(1,0,0,0,0,16'h4444, 1,2'd1,4'b0010,4'b0000,0,2'd0,4'b0000,32'd0,0,32'd0,3'd1);
        vecs[4]  = mk(1,0,0,0,0,16'h4444, 1,2'd2,4'b0100,4'b0000,0,2'd0,4'b0000,32'd0,0,32'd0,3'd2);
        vecs[5]  = mk(1,0,0,0,0,16'h4444, 1,2'd3,4'b1000,4'b0000,0,2'd0,4'b0000,32'd0,0,32'd0,3'd3);
        vecs[6]  = mk(1,0,0,0,0,16'h4444, 0,2'd0,4'b0000,4'b0000,0,2'd0,4'b0000,32'd0,0,32'd0,3'd4);
        // commit two, drain both with wr_ready high
        vecs[7]  = mk(0,1,0,1,0,16'h4444, 0,2'd0,4'b0000,4'b0000,0,2'd0,4'b0000,32'd0,0,32'd0,3'd4);
        vecs[8]  = mk(0,1,0,1,0,16'h4444, 0,2'd0,4'b0000,4'b0000,0,2'd0,4'b0000,32'd0,0,32'd0,3'd4);
        vecs[9]  = mk(0,0,0,1,0,16'h4444, 0,2'd0,4'b0000,4'b0001,1,2'd0,4'b0100,PA0,  0,32'd0,3'd4);
        vecs[10] = mk(0,0,0,1,0,16'h4444, 1,2'd0,4'b0000,4'b0000,0,2'd1,4'b0000,32'd0,0,32'd0,3'd3);
        vecs[11] = mk(0,0,0,1,0,16'h4444, 1,2'd0,4'b0000,4'b0010,1,2'd1,4'b0100,PA1,  0,32'd0,3'd3);
        vecs[12] = mk(0,0,0,1,0,16'h4444, 1,2'd0,4'b0000,4'b0000,0,2'd2,4'b0000,32'd0,0,32'd0,3'd2);
        // flush uncommitted entries 2,3
        vecs[13] = mk(0,0,1,0,0,16'h4444, 0,2'd0,4'b0000,4'b1100,0,2'd2,4'b0000,32'd0,0,32'd0,3'd2);
        vecs[14] = mk(0,0,0,0,0,16'h4444, 1,2'd2,4'b0000,4'b0000,0,2'd2,4'b0000,32'd0,0,32'd0,3'd0);
        // entry 2 with no hit: miss, then hit way 0 and ack
        vecs[15] = mk(1,0,0,0,0,16'h4044, 1,2'd2,4'b0100,4'b0000,0,2'd2,4'b0000,32'd0,0,32'd0,3'd0);
        vecs[16] = mk(0,1,0,0,0,16'h4044, 1,2'd3,4'b0000,4'b0000,0,2'd2,4'b0000,32'd0,0,32'd0,3'd1);
        vecs[17] = mk(0,0,0,0,0,16'h4044, 1,2'd3,4'b0000,4'b0000,0,2'd2,4'b0000,32'd0,0,32'd0,3'd1);
        vecs[18] = mk(0,0,0,0,0,16'h4044, 1,2'd3,4'b0000,4'b0000,0,2'd2,4'b0000,32'd0,1,PA2,  3'd1);
        vecs[19] = mk(0,0,0,0,1,16'h4144, 1,2'd3,4'b0000,4'b0000,0,2'd2,4'b0000,32'd0,1,PA2,  3'd1);
        vecs[20] = mk(0,0,0,0,0,16'h4144, 1,2'd3,4'b0000,4'b0000,0,2'd2,4'b0000,32'd0,0,32'd0,3'd1);
        // WRITE stalled, then snoop removes the hit: valid withdrawn, miss
        vecs[21] = mk(0,0,0,0,0,16'h4144, 1,2'd3,4'b0000,4'b0000,1,2'd2,4'b0001,PA2,  0,32'd0,3'd1);
        vecs[22] = mk(0,0,0,0,0,16'h4044, 1,2'd3,4'b0000,4'b0000,0,2'd2,4'b0000,PA2,  0,32'd0,3'd1);
        vecs[23] = mk(0,0,0,1,0,16'h4044, 1,2'd3,4'b0000,4'b0000,0,2'd2,4'b0000,32'd0,1,PA2,  3'd1);
        vecs[24] = mk(0,0,0,0,1,16'h4144, 1,2'd3,4'b0000,4'b0000,0,2'd2,4'b0000,32'd0,1,PA2,  3'd1);
        vecs[25] = mk(0,0,0,0,0,16'h4144, 1,2'd3,4'b0000,4'b0000,0,2'd2,4'b0000,32'd0,0,32'd0,3'd1);
        vecs[26] = mk(0,0,0,1,0,16'h4144, 1,2'd3,4'b0000,4'b0100,1,2'd2,4'b0001,PA2,  0,32'd0,3'd1);
        // wrap: push 3,0,1 with commit alongside, then flush+commit+drain together
        vecs[27] = mk(1,0,0,0,0,16'h4144, 1,2'd3,4'b1000,4'b0000,0,2'd3,4'b0000,32'd0,0,32'd0,3'd0);
        vecs[28] = mk(1,1,0,0,0,16'h4144, 1,2'd0,4'b0001,4'b0000,0,2'd3,4'b0000,32'd0,0,32'd0,3'd1);
        vecs[29] = mk(1,0,0,0,0,16'h4144, 1,2'd1,4'b0010,4'b0000,0,2'd3,4'b0000,32'd0,0,32'd0,3'd2);
        vecs[30] = mk(0,1,1,1,0,16'h4144, 0,2'd2,4'b0000,4'b1010,1,2'd3,4'b0100,PA3,  0,32'd0,3'd3);
        vecs[31] = mk(0,0,0,1,0,16'h4144, 1,2'd1,4'b0000,4'b0000,0,2'd0,4'b0000,32'd0,0,32'd0,3'd1);
        vecs[32] = mk(0,0,0,1,0,16'h4144, 1,2'd1,4'b0000,4'b0001,1,2'd0,4'b0100,PA0,  0,32'd0,3'd1);
        vecs[33] = mk(0,0,0,0,0,16'h4144, 1,2'd1,4'b0000,4'b0000,0,2'd1,4'b0000,32'd0,0,32'd0,3'd0);

        rst_n = 1'b0;
        drive_idle();
        set_hits(16'h4444);

        repeat (2) @(negedge clk);
        #1;
        chk_reset_outs(-1);

        // Release between edges so the INIT cycle is sampled before the next rise.
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            push_valid = vecs[i].pv;
            commit     = vecs[i].cm;
            flush      = vecs[i].fl;
            wr_ready   = vecs[i].wrr;
            miss_ack   = vecs[i].ack;
            set_hits(vecs[i].hit);
            #1;
            chk("push_ready", i, 32'(push_ready), 32'(vecs[i].prdy));
            chk("push_idx",   i, 32'(push_idx),   32'(vecs[i].pidx));
            chk("ent_set",    i, 32'(ent_set),    32'(vecs[i].set));
            chk("ent_clr",    i, 32'(ent_clr),    32'(vecs[i].clr));
            chk("wr_valid",   i, 32'(wr_valid),   32'(vecs[i].wv));
            chk("wr_idx",     i, 32'(wr_idx),     32'(vecs[i].widx));
            chk("wr_way",     i, 32'(wr_way),     32'(vecs[i].wway));
            chk("wr_paddr",   i, wr_paddr,        vecs[i].wpa);
            chk("miss_req",   i, 32'(miss_req),   32'(vecs[i].mreq));
            chk("miss_paddr", i, miss_paddr,      vecs[i].mpa);
            chk("count",      i, 32'(count),      32'(vecs[i].cnt));
            chk("full",       i, 32'(full),       32'(vecs[i].cnt == 3'd4));
            chk("empty",      i, 32'(empty),      32'(vecs[i].cnt == 3'd0));
        end

        // Reset mid-operation: push entry 1, commit it, reach WRITE, then reset.
        @(negedge clk);
        drive_idle();
        push_valid = 1'b1;
        #1;
        chk("mid push_set", 100, 32'(ent_set), 32'(4'b0010));
        @(negedge clk);
        push_valid = 1'b0;
        commit     = 1'b1;
        @(negedge clk);
        commit     = 1'b0;
        @(negedge clk);
        #1;
        chk("mid wr_valid", 101, 32'(wr_valid), 32'd1);
        chk("mid wr_idx",   101, 32'(wr_idx),   32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outs(102);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("reinit ent_clr",    103, 32'(ent_clr),    32'(4'b1111));
        chk("reinit push_ready", 103, 32'(push_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("idle push_ready", 104, 32'(push_ready), 32'd1);
        chk("idle ent_clr",    104, 32'(ent_clr),    32'd0);
        chk("idle count",      104, 32'(count),      32'd0);
        chk("idle empty",      104, 32'(empty),      32'd1);
        chk("idle wr_valid",   104, 32'(wr_valid),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
